// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (one start bit, 8 data bits LSB first, one stop bit).
//
// The serial line goes through a two-flop synchroniser. A start bit is accepted
// only if the line is still low at mid-bit. Each data bit and the stop bit are
// then sampled one full bit time apart, which lands near mid-bit. A good frame
// updates o_RX_Byte and pulses o_RX_DV. A low stop bit pulses o_RX_Frame_Err,
// discards the frame, and waits for the line to return high before it looks for
// a new start bit.
//
// Parameters:
//   CLKS_PER_BIT   clock cycles per UART bit (f_clk / baud), must be >= 4
//
// Ports:
//   i_Clock         system clock, rising edge
//   i_Rst           asynchronous active-high reset
//   i_RX_Serial     asynchronous serial input, idle high
//   o_RX_DV         one-cycle strobe; o_RX_Byte is valid in the same cycle
//   o_RX_Byte       last correctly framed byte, held between frames
//   o_RX_Active     high from a validated start bit until the stop-bit sample
//   o_RX_Frame_Err  one-cycle strobe when the stop bit is sampled low
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  // NOTE: every register here is updated with non-blocking assignments so that
  // all flops take the values they had before the edge. This matters most for
  // the synchroniser: rx_s must get the old rx_meta, not the new one.
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      // Synchroniser resets to the idle line level so leaving reset never
      // looks like a start bit.
      rx_meta        <= 1'b1;
      rx_s           <= 1'b1;
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shift_reg      <= '0;
      o_RX_DV        <= 1'b0;
      o_RX_Byte      <= '0;
      o_RX_Active    <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_s    <= rx_meta;

      // Strobes are low unless a state below raises them for this one cycle.
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;

      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (!rx_s) state <= START;
        end

        START: begin
          if (cnt < HALF_CNT) begin
            cnt <= cnt + 1'b1;
          end else if (!rx_s) begin
            // Still low at mid start bit: a real frame. From here on every
            // full bit period lands on the middle of the next bit.
            cnt         <= '0;
            state       <= DATA;
            o_RX_Active <= 1'b1;
          end else begin
            // Line went back high: glitch, no output activity.
            state <= IDLE;
          end
        end

        DATA: begin
          if (cnt < LAST_CNT) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx < 3'd7) begin
              bit_idx <= bit_idx + 1'b1;
            end else begin
              bit_idx <= '0;
              state   <= STOP;
            end
          end
        end

        STOP: begin
          if (cnt < LAST_CNT) begin
            cnt <= cnt + 1'b1;
          end else begin
            // Leave at the stop-bit mid-sample so a start bit that follows the
            // stop bit immediately is still caught.
            cnt         <= '0;
            o_RX_Active <= 1'b0;
            if (rx_s) begin
              o_RX_Byte <= shift_reg;
              o_RX_DV   <= 1'b1;
              state     <= IDLE;
            end else begin
              o_RX_Frame_Err <= 1'b1;
              state          <= BREAK_WAIT;
            end
          end
        end

        BREAK_WAIT: begin
          // A line held low (break) must not be taken as a new start bit.
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
//
// Two receivers run side by side on one clock: dut_a at the default bit rate
// (217 clocks per bit) and dut_b at 4 clocks per bit. The bench serialises
// bytes into 8N1 frames itself. Each good frame pushes its byte onto a queue
// of expected bytes, and each DV pulse must pop the matching byte in order.
// Timing, glitch, break and reset cases run on dut_a. Back-to-back, random
// and full-range loopback traffic runs on dut_b.
module tb_uart_rx;

  localparam int CPB_A = 217;
  localparam int CPB_B = 4;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       line_a = 1'b1;
  logic       line_b = 1'b1;

  logic       dv_a, act_a, err_a;
  logic [7:0] byte_a;
  logic       dv_b, act_b, err_b;
  logic [7:0] byte_b;

  uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
    .i_Clock       (clk),
    .i_Rst         (rst),
    .i_RX_Serial   (line_a),
    .o_RX_DV       (dv_a),
    .o_RX_Byte     (byte_a),
    .o_RX_Active   (act_a),
    .o_RX_Frame_Err(err_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
    .i_Clock       (clk),
    .i_Rst         (rst),
    .i_RX_Serial   (line_b),
    .o_RX_DV       (dv_b),
    .o_RX_Byte     (byte_b),
    .o_RX_Active   (act_b),
    .o_RX_Frame_Err(err_b)
  );

  always #5 clk = ~clk;

  // Count of rising edges so far; read on falling edges.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard state, one set per receiver.
  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  int          dv_cnt_a = 0, err_cnt_a = 0, dv_cnt_b = 0, err_cnt_b = 0;
  int unsigned dv_cyc_a = 0;
  bit          act_seen_a = 1'b0;

  always @(negedge clk) begin
    if (dv_a || err_a) check("a_dv_err_exclusive", 32'(dv_a & err_a), 32'd0);
    if (dv_a) begin
      dv_cnt_a++;
      dv_cyc_a = cyc;
      check("a_dv_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) check("a_byte", 32'(byte_a), 32'(q_a.pop_front()));
    end
    if (err_a) err_cnt_a++;
    if (act_a) act_seen_a = 1'b1;
  end

  always @(negedge clk) begin
    if (dv_b || err_b) check("b_dv_err_exclusive", 32'(dv_b & err_b), 32'd0);
    if (dv_b) begin
      dv_cnt_b++;
      check("b_dv_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) check("b_byte", 32'(byte_b), 32'(q_b.pop_front()));
    end
    if (err_b) err_cnt_b++;
  end

  int unsigned last_start = 0;

  task automatic drive(input bit sel, input logic v);
    if (sel) line_b = v;
    else     line_a = v;
  endtask

  task automatic hold_bits(input bit sel, input int nbits);
    repeat ((sel ? CPB_B : CPB_A) * nbits) @(negedge clk);
  endtask

  // Called on a falling edge and returns on one. Drives one 8N1 frame. The
  // stop level and its length in bit times can be chosen to model a break.
  task automatic send_frame(input bit sel, input logic [7:0] d,
                            input logic stop_bit, input int stop_bits);
    drive(sel, 1'b0);
    last_start = cyc;
    hold_bits(sel, 1);
    for (int k = 0; k < 8; k++) begin
      drive(sel, d[k]);
      hold_bits(sel, 1);
    end
    drive(sel, stop_bit);
    hold_bits(sel, stop_bits);
    drive(sel, 1'b1);
  endtask

  task automatic send_good(input bit sel, input logic [7:0] d);
    if (sel) q_b.push_back(d);
    else     q_a.push_back(d);
    send_frame(sel, d, 1'b1, 1);
  endtask

  int dv0, err0;
  logic [7:0] rb;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dv_a",   32'(dv_a),   32'd0);
    check("rst_byte_a", 32'(byte_a), 32'd0);
    check("rst_act_a",  32'(act_a),  32'd0);
    check("rst_err_a",  32'(err_a),  32'd0);
    check("rst_dv_b",   32'(dv_b),   32'd0);
    check("rst_byte_b", 32'(byte_b), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single 0xA5 frame with exact latency. DV is high in the cycle after
    // edge e0 + 3 + HALF + 9*CPB, where e0 is the edge after the line drops.
    send_good(1'b0, 8'hA5);
    repeat (20) @(negedge clk);
    check("a5_dv_count",  32'(dv_cnt_a), 32'd1);
    check("a5_err_count", 32'(err_cnt_a), 32'd0);
    check("a5_dv_cycle",  dv_cyc_a, last_start + 1 + 3 + (CPB_A - 1) / 2 + 9 * CPB_A);
    check("a5_byte_held", 32'(byte_a), 32'hA5);

    // Glitch: low for 50 cycles, shorter than half a bit.
    dv0 = dv_cnt_a; err0 = err_cnt_a; act_seen_a = 1'b0;
    drive(1'b0, 1'b0);
    repeat (50) @(negedge clk);
    drive(1'b0, 1'b1);
    repeat (300) @(negedge clk);
    check("glitch_active", 32'(act_seen_a), 32'd0);
    check("glitch_dv",     32'(dv_cnt_a),   32'(dv0));
    check("glitch_err",    32'(err_cnt_a),  32'(err0));
    send_good(1'b0, 8'h81);
    repeat (20) @(negedge clk);
    check("after_glitch_dv", 32'(dv_cnt_a), 32'(dv0 + 1));

    // 0x55 with a low stop bit, line held low for 5 bit times in total.
    dv0 = dv_cnt_a; err0 = err_cnt_a;
    send_frame(1'b0, 8'h55, 1'b0, 1);
    drive(1'b0, 1'b0);
    act_seen_a = 1'b0;
    hold_bits(1'b0, 4);
    check("break_no_restart", 32'(act_seen_a), 32'd0);
    drive(1'b0, 1'b1);
    hold_bits(1'b0, 1);
    check("break_err_count", 32'(err_cnt_a), 32'(err0 + 1));
    check("break_no_dv",     32'(dv_cnt_a),  32'(dv0));
    check("break_byte_kept", 32'(byte_a),    32'h81);
    send_good(1'b0, 8'h12);
    repeat (20) @(negedge clk);
    check("after_break_dv", 32'(dv_cnt_a), 32'(dv0 + 1));

    // Reset in the middle of data bit 4 of 0xF0.
    dv0 = dv_cnt_a; err0 = err_cnt_a;
    rb = 8'hF0;
    drive(1'b0, 1'b0);
    hold_bits(1'b0, 1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, rb[k]);
      hold_bits(1'b0, 1);
    end
    drive(1'b0, rb[4]);
    repeat (CPB_A / 2) @(negedge clk);
    check("mid_frame_active", 32'(act_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dv",   32'(dv_a),   32'd0);
    check("async_rst_byte", 32'(byte_a), 32'd0);
    check("async_rst_act",  32'(act_a),  32'd0);
    check("async_rst_err",  32'(err_a),  32'd0);
    @(negedge clk);
    drive(1'b0, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (CPB_A * 6) @(negedge clk);
    check("rst_abandon_dv",  32'(dv_cnt_a),  32'(dv0));
    check("rst_abandon_err", 32'(err_cnt_a), 32'(err0));
    send_good(1'b0, 8'h6B);
    repeat (20) @(negedge clk);
    check("after_rst_dv",   32'(dv_cnt_a), 32'(dv0 + 1));
    check("after_rst_byte", 32'(byte_a),   32'h6B);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);

    // Fast instance: back-to-back frames with no idle gap.
    send_good(1'b1, 8'h00);
    send_good(1'b1, 8'hFF);
    send_good(1'b1, 8'h3C);
    repeat (20) @(negedge clk);
    check("b2b_dv_count", 32'(dv_cnt_b), 32'd3);

    // Random bytes with random idle gaps of 0..3 cycles.
    for (int i = 0; i < 40; i++) begin
      send_good(1'b1, 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Loopback of every byte value, in order, back-to-back.
    for (int i = 0; i < 256; i++) send_good(1'b1, 8'(i));
    repeat (50) @(negedge clk);
    check("b_dv_total",      32'(dv_cnt_b),    32'd299);
    check("b_err_total",     32'(err_cnt_b),   32'd0);
    check("b_queue_drained", 32'(q_b.size()),  32'd0);
    check("b_last_byte",     32'(byte_b),      32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
